// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed 7-segment display driver.
// Glyphs are active-low, bit order gfedcba (bit 6 = g, bit 0 = a).
package seg7_pkg;

  localparam int unsigned GLYPH_W = 7;
  localparam int unsigned NIB_W   = 4;

  localparam logic [GLYPH_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [GLYPH_W-1:0] GLYPH_0 = 7'b1000000;
  localparam logic [GLYPH_W-1:0] GLYPH_1 = 7'b1111001;
  localparam logic [GLYPH_W-1:0] GLYPH_2 = 7'b0100100;
  localparam logic [GLYPH_W-1:0] GLYPH_3 = 7'b0110000;
  localparam logic [GLYPH_W-1:0] GLYPH_4 = 7'b0011001;
  localparam logic [GLYPH_W-1:0] GLYPH_5 = 7'b0010010;
  localparam logic [GLYPH_W-1:0] GLYPH_6 = 7'b0000010;
  localparam logic [GLYPH_W-1:0] GLYPH_7 = 7'b1111000;
  localparam logic [GLYPH_W-1:0] GLYPH_8 = 7'b0000000;
  localparam logic [GLYPH_W-1:0] GLYPH_9 = 7'b0010000;
  localparam logic [GLYPH_W-1:0] GLYPH_A = 7'b0001000;
  localparam logic [GLYPH_W-1:0] GLYPH_B = 7'b0000011;
  localparam logic [GLYPH_W-1:0] GLYPH_C = 7'b1000110;
  localparam logic [GLYPH_W-1:0] GLYPH_D = 7'b0100001;
  localparam logic [GLYPH_W-1:0] GLYPH_E = 7'b0000110;
  localparam logic [GLYPH_W-1:0] GLYPH_F = 7'b0001110;

  // Hex nibble to active-low glyph.
  function automatic logic [GLYPH_W-1:0] hex_glyph(input logic [NIB_W-1:0] nib);
    logic [GLYPH_W-1:0] g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational hex nibble to active-low gfedcba glyph.
// Ports:
//   nibble_i  in  4  hex digit
//   glyph_o   out 7  active-low segments, gfedcba
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0]   nibble_i,
  output logic [GLYPH_W-1:0] glyph_o
);

  assign glyph_o = hex_glyph(nibble_i);

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: tear-free multiplexed 7-segment driver.
// Scans NUM_DIGITS hex digits onto shared active-low segment/anode lines,
// SCAN_DIV clocks per digit. Loaded values are staged and committed only at
// a frame boundary so a frame never mixes old and new digits.
// Optional blinking is compiled in with `define SEG7_BLINK_EN.
// Ports:
//   clk, clr        clock, synchronous active-high reset
//   value, load     hex nibbles (digit 0 rightmost), capture strobe
//   dp_in           per-digit decimal point request
//   digit_en        per-digit enable (0 = dark)
//   lzs_en          leading-zero suppression
//   blink           per-digit blink request (ignored without SEG7_BLINK_EN)
//   a_to_g, an, dp  registered active-low segments, anodes, decimal point
//   pending         staged value awaiting commit
//   frame_done      pulse on the last cycle of each frame
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 131072,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      load,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      lzs_en,
  input  logic [NUM_DIGITS-1:0]     blink,
  output logic [GLYPH_W-1:0]        a_to_g,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      dp,
  output logic                      pending,
  output logic                      frame_done
);

  localparam int unsigned VAL_W = NIB_W * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  // Elaboration-time parameter range check.
  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_param
    $error("seg7_scan_display: parameter out of range");
  end

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VAL_W-1:0]   staging_q, staging_d;
  logic [VAL_W-1:0]   shown_q, shown_d;
  logic               pending_q, pending_d;
  logic [GLYPH_W-1:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic               dp_q, dp_d;
  logic               blink_phase_d;

  logic               tick;
  logic               frame_end;
  logic [NIB_W-1:0]   nib;
  logic [GLYPH_W-1:0] glyph;

  assign tick      = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign frame_end = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Prescaler and digit index.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Double buffer: a load on the boundary cycle bypasses staging.
  always_comb begin
    staging_d = staging_q;
    shown_d   = shown_q;
    pending_d = pending_q;
    if (load) begin
      staging_d = value;
    end
    if (frame_end) begin
      if (load) begin
        shown_d = value;
      end else if (pending_q) begin
        shown_d = staging_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FR_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_phase_q;

  // Frame counter toggles the blink phase every BLINK_FRAMES frames.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (frame_cnt_q == FR_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  assign blink_phase_d = 1'b0;
`endif

  // Output stage works on next-state idx/shown so the registered pins
  // switch to the new digit together with idx.
  always_comb begin
    logic                  run;
    logic [NUM_DIGITS-1:0] lit_vec;
    logic                  lit;
    logic                  dp_sel;
    nib     = '0;
    run     = 1'b1;
    lit_vec = '0;
    lit     = 1'b0;
    dp_sel  = 1'b0;
    an_d    = '1;
    // Walk from the most significant digit; run stays high while all zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run & (shown_d[NIB_W*i +: NIB_W] == '0);
      lit_vec[i] = digit_en[i] & ~(lzs_en & run & (i != 0)) &
                   ~(blink[i] & blink_phase_d);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib    = shown_d[NIB_W*i +: NIB_W];
        lit    = lit_vec[i];
        dp_sel = dp_in[i];
        an_d[i] = ~lit_vec[i];
      end
    end
    seg_d = lit ? glyph : SEG_BLANK;
    dp_d  = lit ? ~dp_sel : 1'b1;
  end

  seg7_hex_decoder u_dec (
    .nibble_i (nib),
    .glyph_o  (glyph)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      staging_q <= '0;
      shown_q   <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
      dp_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      shown_q   <= shown_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
    end
  end

  assign a_to_g     = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign pending    = pending_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Testbench for seg7_scan_display with NUM_DIGITS=4, SCAN_DIV=4.
module tb_seg7_scan_display;

  localparam logic [6:0] B = 7'b1111111;

  logic        clk;
  logic        clr;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lzs_en;
  logic [3:0]  blink;
  logic [6:0]  a_to_g;
  logic [3:0]  an;
  logic        dp;
  logic        pending;
  logic        frame_done;

  int total;
  int passed;

  seg7_scan_display #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .value      (value),
    .load       (load),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lzs_en     (lzs_en),
    .blink      (blink),
    .a_to_g     (a_to_g),
    .an         (an),
    .dp         (dp),
    .pending    (pending),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     value;
    logic            lzs;
    logic [3:0]      en;
    logic [3:0]      dpi;
    logic [3:0][3:0] an;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
  } vec_t;

  vec_t vecs [7];

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    if (frame_done !== 1'b1) begin
      total++;
      $display("FAIL wait_frame_done: got timeout expected pulse within 64 cycles");
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    int errs;
    total = 0;
    passed = 0;
    clr = 1'b0; value = '0; load = 1'b0; dp_in = '0;
    digit_en = 4'b1111; lzs_en = 1'b0; blink = '0;

    vecs[0] = '{16'h1A3F, 1'b0, 4'b1111, 4'b0000,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}, 4'b1111};
    vecs[1] = '{16'h0050, 1'b1, 4'b1111, 4'b0000,
                {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {B, B, 7'b0010010, 7'b1000000}, 4'b1111};
    vecs[2] = '{16'h0000, 1'b1, 4'b1111, 4'b0000,
                {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {B, B, B, 7'b1000000}, 4'b1111};
    vecs[3] = '{16'h1A3F, 1'b0, 4'b0101, 4'b0001,
                {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                {B, 7'b0001000, B, 7'b0001110}, 4'b1110};
    vecs[4] = '{16'h8D2C, 1'b0, 4'b1111, 4'b1010,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0000000, 7'b0100001, 7'b0100100, 7'b1000110}, 4'b0101};
    vecs[5] = '{16'h0B06, 1'b1, 4'b1111, 4'b0000,
                {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {B, 7'b0000011, 7'b1000000, 7'b0000010}, 4'b1111};
    vecs[6] = '{16'h4E97, 1'b0, 4'b1111, 4'b0000,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0011001, 7'b0000110, 7'b0010000, 7'b1111000}, 4'b1111};

    // Reset values
    step();
    clr = 1'b1;
    step();
    chk("rst_a_to_g", 32'(a_to_g), 32'(7'b1111111));
    chk("rst_an", 32'(an), 32'(4'b1111));
    chk("rst_dp", 32'(dp), 32'(1'b1));
    chk("rst_pending", 32'(pending), 32'(1'b0));
    chk("rst_frame_done", 32'(frame_done), 32'(1'b0));
    clr = 1'b0;

    // Table: load, wait for commit, check each slot of the new frame.
    for (int v = 0; v < 7; v++) begin
      lzs_en   = vecs[v].lzs;
      digit_en = vecs[v].en;
      dp_in    = vecs[v].dpi;
      do_load(vecs[v].value);
      chk($sformatf("v%0d_pending", v), 32'(pending), 32'(1'b1));
      wait_fd();
      step();
      for (int s = 0; s < 4; s++) begin
        chk($sformatf("v%0d_s%0d_an", v, s), 32'(an), 32'(vecs[v].an[s]));
        chk($sformatf("v%0d_s%0d_seg", v, s), 32'(a_to_g), 32'(vecs[v].seg[s]));
        chk($sformatf("v%0d_s%0d_dp", v, s), 32'(dp), 32'(vecs[v].dpo[s]));
        if (s < 3) step(4);
      end
    end

    // Mid-frame update must not tear the current frame.
    lzs_en = 1'b0; digit_en = 4'b1111; dp_in = 4'b0000;
    do_load(16'h2222);
    wait_fd();
    step();
    step(4);
    do_load(16'h1111);
    chk("mid_pending", 32'(pending), 32'(1'b1));
    step(3);
    chk("mid_s2_an", 32'(an), 32'(4'b1011));
    chk("mid_s2_seg", 32'(a_to_g), 32'(7'b0100100));
    step(4);
    chk("mid_s3_an", 32'(an), 32'(4'b0111));
    chk("mid_s3_seg", 32'(a_to_g), 32'(7'b0100100));
    wait_fd();
    chk("mid_pending_at_fd", 32'(pending), 32'(1'b1));
    step();
    chk("mid_commit_seg", 32'(a_to_g), 32'(7'b1111001));
    chk("mid_commit_an", 32'(an), 32'(4'b1110));
    chk("mid_commit_pending", 32'(pending), 32'(1'b0));

    // Load coincident with frame boundary commits directly.
    wait_fd();
    do_load(16'h0007);
    chk("coin_pending", 32'(pending), 32'(1'b0));
    chk("coin_seg", 32'(a_to_g), 32'(7'b1111000));
    chk("coin_an", 32'(an), 32'(4'b1110));

    // digit_en / dp_in over three frames.
    digit_en = 4'b0101;
    dp_in    = 4'b0001;
    errs = 0;
    for (int c = 0; c < 48; c++) begin
      step();
      if (an[1] !== 1'b1 || an[3] !== 1'b1) errs++;
      if ((an === 4'b1110) !== (dp === 1'b0)) errs++;
    end
    chk("en_dp_scan_errors", 32'(errs), 32'd0);

    // clr mid-frame with a pending value discards it.
    wait_fd();
    step();
    step(8);
    do_load(16'h1234);
    chk("clr_pre_pending", 32'(pending), 32'(1'b1));
    clr = 1'b1;
    load = 1'b1;
    step();
    clr = 1'b0;
    load = 1'b0;
    chk("clr_an", 32'(an), 32'(4'b1111));
    chk("clr_seg", 32'(a_to_g), 32'(7'b1111111));
    chk("clr_pending", 32'(pending), 32'(1'b0));
    digit_en = 4'b1111;
    dp_in    = 4'b0000;
    wait_fd();
    step();
    chk("clr_discard_seg", 32'(a_to_g), 32'(7'b1000000));
    chk("clr_discard_pending", 32'(pending), 32'(1'b0));

`ifdef SEG7_BLINK_EN
    // Blink: BLINK_FRAMES=2, digit 0 dark in frames 2-3.
    blink = 4'b0001;
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    chk("blink_f0_an", 32'(an), 32'(4'b1110));
    for (int f = 1; f < 6; f++) begin
      wait_fd();
      step();
      chk($sformatf("blink_f%0d_an", f), 32'(an),
          (f == 2 || f == 3) ? 32'(4'b1111) : 32'(4'b1110));
      if (f == 2) begin
        step(4);
        chk("blink_f2_s1_an", 32'(an), 32'(4'b1101));
      end
    end
    blink = 4'b0000;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
